// File: rtl/eth_crc_pkg.sv
// Shared CRC-32 constants, the byte-wise CRC update and the FCS checker state type.
package eth_crc_pkg;

    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;
    localparam logic [31:0] CRC32_XOROUT    = 32'hFFFFFFFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2
    } fcs_rx_state_e;

    // Reflected CRC-32 over one byte, bits consumed LSB first.
    function automatic logic [31:0] crc32_upd_byte(input logic [31:0] crc,
                                                   input logic [7:0]  data);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ CRC32_POLY_REFL;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/fcs_delay_line.sv
// Four-byte shift register that holds back the trailing FCS bytes of a frame.
// dout is the oldest held byte; it is only meaningful once full is set.
module fcs_delay_line (
    input  logic       clk,
    input  logic       rst,
    input  logic       shift_en,
    input  logic       clear,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full
);

    logic [7:0] sr [4];
    logic [2:0] cnt;

    // Shift in each accepted byte; clear wins so a frame end leaves the line empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                sr[i] <= '0;
            end
            cnt <= '0;
        end else if (clear) begin
            for (int i = 0; i < 4; i++) begin
                sr[i] <= '0;
            end
            cnt <= '0;
        end else if (shift_en) begin
            sr[0] <= din;
            sr[1] <= sr[0];
            sr[2] <= sr[1];
            sr[3] <= sr[2];
            if (cnt != 3'd4) begin
                cnt <= cnt + 3'd1;
            end
        end
    end

    assign dout = sr[3];
    assign full = (cnt == 3'd4);

endmodule

// File: rtl/ethernet_fcs_rx_check.sv
// Receive-side Ethernet FCS checker: strips the 4 FCS bytes from the byte
// stream, checks the CRC-32 residue and reports one status record per frame.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | between frames, delay line empty
//   FILL   | 1-3 bytes of the current frame held, nothing emitted yet
//   STREAM | 4 bytes held, every further byte pushes one payload byte out
module ethernet_fcs_rx_check
    import eth_crc_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    input  logic [7:0]       s_data,
    input  logic             s_last,
    output logic             m_valid,
    output logic [7:0]       m_data,
    output logic             m_last,
    output logic             stat_valid,
    output logic             stat_fcs_ok,
    output logic             stat_runt,
    output logic [LEN_W-1:0] stat_len
);

    fcs_rx_state_e    state;
    fcs_rx_state_e    state_nx;
    logic [1:0]       fill_cnt;
    logic [1:0]       fill_nx;
    logic [31:0]      crc;
    logic [31:0]      crc_nx;
    logic [LEN_W-1:0] len_cnt;
    logic [LEN_W-1:0] len_inc;
    logic [7:0]       dl_dout;
    logic             dl_full;
    logic             frame_end;
    logic             emit;
    logic             runt;

    assign frame_end = s_valid & s_last;
    assign crc_nx    = crc32_upd_byte(crc, s_data);
    assign len_inc   = (&len_cnt) ? len_cnt : len_cnt + LEN_W'(1);

    fcs_delay_line u_delay (
        .clk      (clk),
        .rst      (rst),
        .shift_en (s_valid),
        .clear    (frame_end),
        .din      (s_data),
        .dout     (dl_dout),
        .full     (dl_full)
    );

    // State register; fill_cnt tracks how many bytes FILL has taken so far.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            fill_cnt <= '0;
        end else begin
            state    <= state_nx;
            fill_cnt <= fill_nx;
        end
    end

    // Next state plus per-byte decisions: emit a payload byte, or flag a runt.
    always_comb begin
        state_nx = state;
        fill_nx  = fill_cnt;
        emit     = 1'b0;
        runt     = 1'b0;
        case (state)
            IDLE: begin
                if (s_valid) begin
                    if (s_last) begin
                        runt = 1'b1;
                    end else begin
                        state_nx = FILL;
                        fill_nx  = 2'd1;
                    end
                end
            end
            FILL: begin
                if (s_valid) begin
                    if (s_last) begin
                        runt     = 1'b1;
                        state_nx = IDLE;
                        fill_nx  = '0;
                    end else if (fill_cnt == 2'd3) begin
                        state_nx = STREAM;
                        fill_nx  = '0;
                    end else begin
                        fill_nx = fill_cnt + 2'd1;
                    end
                end
            end
            STREAM: begin
                if (s_valid) begin
                    emit = dl_full;
                    if (s_last) begin
                        state_nx = IDLE;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                fill_nx  = '0;
            end
        endcase
    end

    // Running CRC over every frame byte, FCS included; re-armed at frame end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc <= CRC32_INIT;
        end else if (s_valid) begin
            crc <= s_last ? CRC32_INIT : crc_nx;
        end
    end

    // Saturating count of payload bytes emitted in the current frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_cnt <= '0;
        end else if (frame_end) begin
            len_cnt <= '0;
        end else if (emit) begin
            len_cnt <= len_inc;
        end
    end

    // Registered payload and status outputs; the last payload byte and the
    // status pulse come from the same accept, so they line up on one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid     <= 1'b0;
            m_data      <= '0;
            m_last      <= 1'b0;
            stat_valid  <= 1'b0;
            stat_fcs_ok <= 1'b0;
            stat_runt   <= 1'b0;
            stat_len    <= '0;
        end else begin
            m_valid    <= emit;
            m_last     <= emit & s_last;
            stat_valid <= frame_end;
            if (emit) begin
                m_data <= dl_dout;
            end
            if (frame_end) begin
                stat_fcs_ok <= (crc_nx == CRC32_RESIDUE);
                stat_runt   <= runt;
                stat_len    <= runt ? '0 : len_inc;
            end
        end
    end

endmodule

// File: doc/ethernet_fcs_rx_check.md
# ethernet_fcs_rx_check

Receive-side Ethernet FCS checker and stripper. It sits between the MAC RX byte stream and the frame buffer, and consumes frames that still carry their 4 FCS bytes. It forwards the payload with the FCS removed and reports one status record per frame. The CRC is Ethernet CRC-32: reflected polynomial 0xEDB88320, init 0xFFFFFFFF, LSB-first.

## Interface
- `LEN_W`, default 16: width of the payload byte counter in the status record.
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `s_valid`  in  1: input byte valid. There is no backpressure; the block accepts every byte.
- `s_data`  in  8: input byte, in wire order.
- `s_last`  in  1: marks the final byte of a frame (the last FCS byte). Qualified by `s_valid`.
- `m_valid`  out  1: payload byte valid.
- `m_data`  out  8: payload byte.
- `m_last`  out  1: marks the final payload byte.
- `stat_valid`  out  1: one-cycle status pulse, one per frame.
- `stat_fcs_ok`  out  1: the CRC residue matched.
- `stat_runt`  out  1: the frame had fewer than 5 bytes in total, so no payload.
- `stat_len`  out  `LEN_W`: payload byte count. Saturates at all-ones.

## Operation
- **Running CRC register `crc`**
  - Reset and end-of-frame value: 0xFFFFFFFF.
  - On each accepted byte: `crc_nx = crc32_upd_byte(crc, s_data)`.
  - Every frame byte goes through the update, including the FCS bytes.
- **FCS check.** On the `s_last` byte, `stat_fcs_ok = (crc_nx == CRC32_RESIDUE)`, where the residue is 0xDEBB20E3. The check uses the raw register, with no final XOR.
- **4-byte delay line.** This is how the FCS is stripped.
  - Each accepted byte shifts in.
  - Once 4 bytes are held, each further accepted byte shifts the oldest byte out to `m_data`.
  - So when `s_last` arrives, the 4 newest bytes are the FCS and are discarded. The byte shifted out on that same accept is the last payload byte, and it carries `m_last` = 1.
- **FSM states.** `IDLE`, `FILL` (1–3 bytes held), `STREAM` (4 bytes held).
  - `IDLE` to `FILL`: accepted byte without `s_last`.
  - `FILL` to `STREAM`: the 4th byte is accepted without `s_last`.
  - `STREAM` stays in `STREAM` on each non-last byte and emits a payload byte.
  - From any state, an accepted `s_last` returns to `IDLE`. This clears the fill count, the CRC register and the length counter.
- **Runt frames.**
  - Definition: `s_last` arrives in `IDLE` or `FILL`, i.e. the frame has 1–4 bytes in total.
  - Response: no `m_valid` at all. `stat_valid` = 1, `stat_runt` = 1, `stat_len` = 0, and `stat_fcs_ok` is still computed.
- **Length.** `stat_len` counts emitted payload bytes and saturates; it does not wrap.
- **Gaps.** When `s_valid` = 0, everything holds. Gaps of any length inside a frame are legal.
- **Back-to-back frames.** A byte accepted in the cycle right after `s_last` starts the next frame from `IDLE`, with no loss.
- **Reset.**
  - Reset can arrive mid-frame. It forces `IDLE`, clears the delay line and counters, and drops any pending output.
  - The bytes that follow reset are treated as the start of a new frame. The upstream MAC guarantees that reset is released only between frames.

## Timing
- All outputs are registered.
- Reset value of every output: 0.
- Payload latency: payload byte k appears on `m_data` one cycle after input byte k+4 is accepted.
- `m_last` and `stat_valid` are asserted in the same cycle, which is one cycle after the `s_last` accept.
- Without gaps, the output rate equals the input rate: at most 1 byte per cycle, with no bubbles introduced.
- `m_valid`, `m_last` and `stat_valid` are single-cycle pulses per event. `m_data` and the `stat_*` fields are don't-care while their valid is low.

## Structure
- **Package `eth_crc_pkg`**
  - Constants: `CRC32_POLY_REFL` = 0xEDB88320, `CRC32_INIT` = 0xFFFFFFFF, `CRC32_RESIDUE` = 0xDEBB20E3, `CRC32_XOROUT` = 0xFFFFFFFF.
  - `function crc32_upd_byte(crc, byte)`: 8 iterations of shift right, XOR the polynomial when `crc[0] ^ bit` is set, LSB-first.
  - `typedef enum fcs_rx_state_e {IDLE, FILL, STREAM}`.
- **Sub-module `fcs_delay_line`**
  - 4×8 shift register with a fill count of 0–4.
  - Ports: `clk`, `rst`, `shift_en`, `clear`, `din`, `dout`, `full`.
  - The top level holds the FSM, the CRC register, the length counter and the output registers.

## Test plan
- Frame 31 32 33 34 35 36 37 38 39 26 39 F4 CB ("123456789" followed by the FCS of CRC 0xCBF43926) -> 9 payload bytes 31..39, `m_last` on 39, `stat_fcs_ok` = 1, `stat_len` = 9, `stat_runt` = 0.
- Same frame with byte 35 changed to 34 -> identical payload, `stat_fcs_ok` = 0.
- Frame 00 00 00 00 (CRC of the empty frame) -> no `m_valid`, `stat_runt` = 1, `stat_fcs_ok` = 1, `stat_len` = 0. 3-byte frame AA BB CC -> `stat_runt` = 1, `stat_fcs_ok` = 0.
- Two copies of frame 1 back-to-back with no idle cycle, then again with random `s_valid` gaps -> two identical outputs and statuses. Outputs during gaps must match the gap-free run byte-for-byte.
- `rst` pulsed after byte 6 of frame 1, then a clean frame 1 -> no `m_valid` or `stat_valid` for the aborted bytes after reset. The clean frame gives `stat_fcs_ok` = 1, `stat_len` = 9.
